// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding address/data bus.
// Data has priority, with a starvation limit for fetch and a wait-state timeout.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        F_REQ,
   input  logic [31:0] F_ADDR,
   output logic [31:0] F_RDATA,
   output logic        F_READY,
   input  logic        D_REQ,
   input  logic        D_WRITE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   output logic [31:0] D_RDATA,
   output logic        D_READY,
   output logic        BUS_ERR,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic        HTRANS,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY
);

   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
   typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

   state_t          state;
   owner_t          owner;
   logic [SW-1:0]   starve_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic            grant_ok;
   logic            data_wins;
   logic            starved;

   // No grant on the edge that ends a READY cycle, so a REQ still held there is not serviced twice.
   always_comb begin
      starved   = (starve_cnt == SW'(STARVE_MAX));
      grant_ok  = (state == ST_IDLE) && !F_READY && !D_READY && (F_REQ || D_REQ);
      data_wins = D_REQ && !(F_REQ && starved);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= ST_IDLE;
         owner      <= OWN_FETCH;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         HADDR      <= '0;
         HWRITE     <= 1'b0;
         HTRANS     <= 1'b0;
         HWDATA     <= '0;
         F_RDATA    <= '0;
         D_RDATA    <= '0;
         F_READY    <= 1'b0;
         D_READY    <= 1'b0;
         BUS_ERR    <= 1'b0;
      end else begin
         F_READY <= 1'b0;
         D_READY <= 1'b0;
         BUS_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_ok) begin
                  state  <= ST_ADDR;
                  HTRANS <= 1'b1;
                  if (data_wins) begin
                     owner  <= OWN_DATA;
                     HADDR  <= D_ADDR;
                     HWRITE <= D_WRITE;
                     if (D_WRITE) HWDATA <= D_WDATA;
                     if (!F_REQ)        starve_cnt <= '0;
                     else if (!starved) starve_cnt <= starve_cnt + 1'b1;
                  end else begin
                     owner      <= OWN_FETCH;
                     HADDR      <= F_ADDR;
                     HWRITE     <= 1'b0;
                     starve_cnt <= '0;
                  end
               end
            end
            ST_ADDR: begin
               state   <= ST_DATA;
               HTRANS  <= 1'b0;
               tmo_cnt <= '0;
            end
            ST_DATA: begin
               if (HREADY) begin
                  state <= ST_IDLE;
                  if (owner == OWN_FETCH) begin
                     F_READY <= 1'b1;
                     F_RDATA <= HRDATA;
                  end else begin
                     D_READY <= 1'b1;
                     if (!HWRITE) D_RDATA <= HRDATA;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  // tmo_cnt holds completed stall cycles, so this edge ends stall cycle TIMEOUT
                  state   <= ST_IDLE;
                  BUS_ERR <= 1'b1;
                  if (owner == OWN_FETCH) F_READY <= 1'b1;
                  else                    D_READY <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed cases with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int SMAX = 4;
   localparam int TMO  = 8;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        F_REQ, D_REQ, D_WRITE, HREADY;
   logic [31:0] F_ADDR, D_ADDR, D_WDATA, HRDATA;
   logic [31:0] F_RDATA, D_RDATA, HADDR, HWDATA;
   logic        F_READY, D_READY, BUS_ERR, HWRITE, HTRANS;

   mem_bus_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET(RESET),
      .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_RDATA(F_RDATA), .F_READY(F_READY),
      .D_REQ(D_REQ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_RDATA(D_RDATA), .D_READY(D_READY), .BUS_ERR(BUS_ERR),
      .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: one transaction in flight; m_t = cycles since grant (0 = address cycle)
   bit          m_busy, m_own_d, m_hwrite, m_f_ready, m_d_ready, m_err;
   int          m_t, m_starve;
   logic [31:0] m_haddr, m_hwdata, m_f_rdata, m_d_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_own_d = 0; m_hwrite = 0; m_t = 0; m_starve = 0;
      m_f_ready = 0; m_d_ready = 0; m_err = 0;
      m_haddr = '0; m_hwdata = '0; m_f_rdata = '0; m_d_rdata = '0;
   endtask

   task automatic finish_txn(input bit err);
      m_busy = 0;
      m_err  = err;
      if (m_own_d) begin
         m_d_ready = 1;
         if (!err && !m_hwrite) m_d_rdata = HRDATA;
      end else begin
         m_f_ready = 1;
         if (!err) m_f_rdata = HRDATA;
      end
   endtask

   task automatic model_step();
      bit was_ready;
      if (!RESET) begin
         model_reset();
         return;
      end
      was_ready = m_f_ready | m_d_ready;
      m_f_ready = 0; m_d_ready = 0; m_err = 0;
      if (m_busy) begin
         if (m_t == 0)        m_t = 1;
         else if (HREADY)     finish_txn(0);
         else if (m_t == TMO) finish_txn(1);
         else                 m_t++;
      end else if (!was_ready && (F_REQ || D_REQ)) begin
         if (D_REQ && !(F_REQ && m_starve == SMAX)) begin
            m_own_d  = 1;
            m_haddr  = D_ADDR;
            m_hwrite = D_WRITE;
            m_hwdata = D_WDATA;
            m_starve = F_REQ ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
         end else begin
            m_own_d  = 0;
            m_haddr  = F_ADDR;
            m_hwrite = 0;
            m_starve = 0;
         end
         m_busy = 1;
         m_t    = 0;
      end
   endtask

   task automatic compare_all();
      check("HTRANS", HTRANS, (m_busy && m_t == 0));
      check("F_READY", F_READY, m_f_ready);
      check("D_READY", D_READY, m_d_ready);
      check("BUS_ERR", BUS_ERR, m_err);
      check("F_RDATA", F_RDATA, m_f_rdata);
      check("D_RDATA", D_RDATA, m_d_rdata);
      if (m_busy) begin
         check("HADDR", HADDR, m_haddr);
         check("HWRITE", HWRITE, m_hwrite);
         if (m_own_d && m_hwrite) check("HWDATA", HWDATA, m_hwdata);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      model_step();
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_HTRANS"}, HTRANS, 0);
      check({tag, "_HWRITE"}, HWRITE, 0);
      check({tag, "_HADDR"}, HADDR, 0);
      check({tag, "_HWDATA"}, HWDATA, 0);
      check({tag, "_F_RDATA"}, F_RDATA, 0);
      check({tag, "_D_RDATA"}, D_RDATA, 0);
      check({tag, "_F_READY"}, F_READY, 0);
      check({tag, "_D_READY"}, D_READY, 0);
      check({tag, "_BUS_ERR"}, BUS_ERR, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit grant_is_data [10];
      int ng;
      int stall;
      bit release_pending;

      RESET = 1'b0; F_REQ = 0; D_REQ = 0; D_WRITE = 0; HREADY = 1;
      F_ADDR = '0; D_ADDR = '0; D_WDATA = '0; HRDATA = '0;
      model_reset();

      // Reset state
      tick(); tick();
      check_all_zero("reset");
      RESET = 1'b1;
      tick();
      check("idle_no_grant", HTRANS, 0);

      // Fetch only, 3-cycle latency
      F_REQ = 1; F_ADDR = 32'h100; HREADY = 1; HRDATA = 32'h0050_0093;
      tick();
      check("fetch_htrans", HTRANS, 1);
      check("fetch_haddr", HADDR, 32'h100);
      tick();
      check("fetch_htrans_data", HTRANS, 0);
      check("fetch_ready_early", F_READY, 0);
      tick();
      check("fetch_ready", F_READY, 1);
      check("fetch_rdata", F_RDATA, 32'h0050_0093);
      F_REQ = 0;
      tick();
      check("fetch_ready_pulse", F_READY, 0);

      // Simultaneous: data store first, then fetch
      F_REQ = 1; F_ADDR = 32'h200; D_REQ = 1; D_WRITE = 1; D_ADDR = 32'h2004;
      D_WDATA = 32'hDEAD_BEEF; HRDATA = 32'hCAFE_F00D;
      tick();
      check("sim_haddr", HADDR, 32'h2004);
      check("sim_hwrite", HWRITE, 1);
      tick();
      check("sim_hwdata", HWDATA, 32'hDEAD_BEEF);
      tick();
      check("sim_d_ready", D_READY, 1);
      check("sim_d_rdata_kept", D_RDATA, 32'h0);
      D_REQ = 0; D_WRITE = 0;
      tick();
      check("sim_no_regrant_on_ready", HTRANS, 0);
      tick();
      check("sim_fetch_haddr", HADDR, 32'h200);
      check("sim_fetch_hwrite", HWRITE, 0);
      tick(); tick();
      check("sim_fetch_rdata", F_RDATA, 32'hCAFE_F00D);
      F_REQ = 0;
      tick();

      // Starvation: both held continuously
      F_REQ = 1; F_ADDR = 32'h300; D_REQ = 1; D_WRITE = 0; D_ADDR = 32'h400;
      HRDATA = 32'h0BAD_F00D;
      ng = 0;
      for (int c = 0; c < 80 && ng < 10; c++) begin
         tick();
         if (HTRANS === 1'b1) begin
            grant_is_data[ng] = (HADDR === 32'h400);
            ng++;
         end
      end
      check("starve_grant_count", ng, 10);
      for (int i = 0; i < 10; i++)
         check($sformatf("starve_grant%0d_is_data", i), grant_is_data[i], (i % 5 != 4));
      F_REQ = 0; D_REQ = 0;
      tick(); tick();
      check("dropped_req_still_ready", F_READY, 1);
      tick(); tick();

      // Wait states: 3 low DATA cycles then HREADY
      D_REQ = 1; D_WRITE = 0; D_ADDR = 32'h500; HREADY = 0;
      tick(); tick(); tick(); tick(); tick();
      check("wait_no_ready", D_READY, 0);
      HREADY = 1; HRDATA = 32'h1234_5678;
      tick();
      check("wait_d_ready", D_READY, 1);
      check("wait_d_rdata", D_RDATA, 32'h1234_5678);
      check("wait_bus_err", BUS_ERR, 0);
      D_REQ = 0;
      tick();

      // Timeout after TMO stalled DATA cycles, then a normal fetch
      F_REQ = 1; F_ADDR = 32'h600; HREADY = 0; HRDATA = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) tick();
      check("tmo_not_yet", F_READY, 0);
      tick();
      check("tmo_ready", F_READY, 1);
      check("tmo_bus_err", BUS_ERR, 1);
      check("tmo_rdata_kept", F_RDATA, 32'h0BAD_F00D);
      F_ADDR = 32'h640; HREADY = 1; HRDATA = 32'h0000_6400;
      tick();
      tick();
      check("tmo_regrant_haddr", HADDR, 32'h640);
      check("tmo_regrant_htrans", HTRANS, 1);
      tick(); tick();
      check("tmo_next_ready", F_READY, 1);
      check("tmo_next_err", BUS_ERR, 0);
      check("tmo_next_rdata", F_RDATA, 32'h0000_6400);
      F_REQ = 0;
      tick();

      // Reset during DATA with fetch owner
      F_REQ = 1; F_ADDR = 32'h700; HREADY = 0;
      tick(); tick();
      RESET = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      tick();
      check("midreset_no_ready", F_READY, 0);
      RESET = 1'b1; HREADY = 1;
      tick();
      check("post_reset_htrans", HTRANS, 1);
      check("post_reset_haddr", HADDR, 32'h700);
      tick(); tick();
      check("post_reset_ready", F_READY, 1);
      F_REQ = 0;
      tick();

      // Randomized traffic
      stall = 0;
      release_pending = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (release_pending) begin
            RESET = 1'b1;
            release_pending = 0;
         end
         HRDATA = $urandom();
         if (stall > 0) begin
            HREADY = 0;
            stall--;
         end else if ($urandom_range(0, 79) == 0) begin
            stall  = $urandom_range(6, 12);
            HREADY = 0;
         end else begin
            HREADY = ($urandom_range(0, 3) != 0);
         end
         if (!F_REQ) begin
            if ($urandom_range(0, 2) == 0) begin
               F_REQ = 1; F_ADDR = $urandom() & 32'hFFFF_FFFC;
            end
         end else if (m_f_ready) begin
            if ($urandom_range(0, 1) == 0) F_REQ = 0;
            else F_ADDR = $urandom() & 32'hFFFF_FFFC;
         end else if ($urandom_range(0, 59) == 0) begin
            F_REQ = 0;
         end
         if (!D_REQ) begin
            if ($urandom_range(0, 1) == 0) begin
               D_REQ = 1; D_WRITE = $urandom_range(0, 1);
               D_ADDR = $urandom(); D_WDATA = $urandom();
            end
         end else if (m_d_ready) begin
            if ($urandom_range(0, 1) == 0) D_REQ = 0;
            else begin
               D_WRITE = $urandom_range(0, 1); D_ADDR = $urandom(); D_WDATA = $urandom();
            end
         end else if ($urandom_range(0, 59) == 0) begin
            D_REQ = 0;
         end
         if (RESET && $urandom_range(0, 399) == 0) begin
            RESET = 1'b0;
            #1;
            model_reset();
            compare_all();
            release_pending = 1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
